// File: rtl/vram_write_buffer_m.sv
// vram_write_buffer_m: buffers upstream VRAM byte writes in a FIFO and drains them only while write_allowed.
// Optional feature macro: VRAM_WRITE_BUFFER_STATS_EN adds the write_total strobe counter port.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif
`ifndef VRAM_SIZE
`define VRAM_SIZE 12'h900
`endif

module vram_write_buffer_m #(
  parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
  parameter int VRAM_SIZE  = `VRAM_SIZE,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic [ADDR_WIDTH-1:0]         in_address,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          write_allowed,
  input  logic                          clear_error,
  output logic [7:0]                    vram_data,
  output logic [ADDR_WIDTH-1:0]         vram_address,
  output logic                          vram_write_enable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          bad_address,
`ifdef VRAM_WRITE_BUFFER_STATS_EN
  output logic [15:0]                   write_total,
`endif
  output logic                          idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + 8;
  localparam logic [CW-1:0]         DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   VRAM_LIMIT = (ADDR_WIDTH + 1)'(VRAM_SIZE);

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic [7:0]             vram_data_reg;
  logic [ADDR_WIDTH-1:0]  vram_address_reg;
  logic                   vram_we_reg;
  logic                   bad_reg;

  logic push_fire, addr_ok, push, pop;

  // Ready and pop both look only at the registered count: no same-cycle bypass.
  assign in_ready  = (count_reg < DEPTH_C);
  assign push_fire = in_valid && in_ready;
  assign addr_ok   = ({1'b0, in_address} < VRAM_LIMIT);
  assign push      = push_fire && addr_ok;
  assign pop       = write_allowed && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_data, in_address};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered read of the FIFO head doubles as the VRAM port output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_data_reg    <= '0;
      vram_address_reg <= '0;
      vram_we_reg      <= 1'b0;
    end else begin
      vram_we_reg <= pop;
      if (pop) begin
        {vram_data_reg, vram_address_reg} <= mem[rd_ptr_reg];
      end
    end
  end

  // A drop in the same cycle as clear_error leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_reg <= 1'b0;
    end else if (push_fire && !addr_ok) begin
      bad_reg <= 1'b1;
    end else if (clear_error) begin
      bad_reg <= 1'b0;
    end
  end

`ifdef VRAM_WRITE_BUFFER_STATS_EN
  logic [15:0] write_total_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_total_reg <= '0;
    end else if (vram_we_reg) begin
      write_total_reg <= write_total_reg + 16'd1;
    end
  end

  assign write_total = write_total_reg;
`endif

  assign vram_data         = vram_data_reg;
  assign vram_address      = vram_address_reg;
  assign vram_write_enable = vram_we_reg;
  assign fifo_count        = count_reg;
  assign bad_address       = bad_reg;
  assign idle              = (count_reg == '0) && !vram_we_reg;

endmodule

// File: tb/tb_vram_write_buffer_m.sv
// tb_vram_write_buffer_m: randomized self-checking bench against a queue-based model of the write buffer.
// Define VRAM_WRITE_BUFFER_STATS_EN to also check write_total.
module tb_vram_write_buffer_m;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [11:0] in_address;
  logic        in_valid;
  logic        in_ready;
  logic        write_allowed;
  logic        clear_error;
  logic [7:0]  vram_data;
  logic [11:0] vram_address;
  logic        vram_write_enable;
  logic [4:0]  fifo_count;
  logic        bad_address;
  logic        idle;
`ifdef VRAM_WRITE_BUFFER_STATS_EN
  logic [15:0] write_total;
`endif

  vram_write_buffer_m dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_data           (in_data),
    .in_address        (in_address),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .write_allowed     (write_allowed),
    .clear_error       (clear_error),
    .vram_data         (vram_data),
    .vram_address      (vram_address),
    .vram_write_enable (vram_write_enable),
    .fifo_count        (fifo_count),
    .bad_address       (bad_address),
`ifdef VRAM_WRITE_BUFFER_STATS_EN
    .write_total       (write_total),
`endif
    .idle              (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  // Model: the FIFO is a queue of pending {data,addr}; the output register is what the last pop produced.
  logic [19:0] mq[$];
  logic        m_we;
  logic [7:0]  m_data;
  logic [11:0] m_addr;
  logic        m_bad;
  logic [15:0] m_total;

  task automatic m_reset();
    mq.delete();
    m_we = 1'b0; m_data = 8'h00; m_addr = 12'h000; m_bad = 1'b0; m_total = 16'h0000;
  endtask

  // Advance one clock edge and update the model from the inputs that edge sampled.
  task automatic step();
    bit acc, pop, legal, clr;
    logic [19:0] e, ent;
    acc   = in_valid && (mq.size() < 16);
    pop   = write_allowed && (mq.size() != 0);
    legal = (in_address < 12'h900);
    clr   = clear_error;
    ent   = {in_data, in_address};
    @(posedge clk); #1;
    if (pop) begin
      e = mq.pop_front();
      m_we = 1'b1; m_data = e[19:12]; m_addr = e[11:0];
      m_total = m_total + 16'd1;
    end else begin
      m_we = 1'b0;
    end
    if (acc && legal) mq.push_back(ent);
    if (acc && !legal) m_bad = 1'b1;
    else if (clr) m_bad = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_data = 0; in_address = 0; write_allowed = 0; clear_error = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (vram_write_enable !== 1'b0) begin errs++; $display("FAIL reset_we got=%b exp=0", vram_write_enable); end
    checks++; if (vram_data !== 8'h00 || vram_address !== 12'h000) begin errs++; $display("FAIL reset_out got=%h@%h exp=00@000", vram_data, vram_address); end
    checks++; if (fifo_count !== 5'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (in_ready !== 1'b1 || idle !== 1'b1 || bad_address !== 1'b0) begin errs++; $display("FAIL reset_flags got ready=%b idle=%b bad=%b exp 1 1 0", in_ready, idle, bad_address); end
    $display("reset released");
  endtask

  task automatic test_single();
    write_allowed = 1; in_valid = 1; in_data = 8'h42; in_address = 12'h005;
    step();
    in_valid = 0;
    checks++; if (vram_write_enable !== 1'b0 || fifo_count !== 5'd1) begin errs++; $display("FAIL single_n1 got we=%b cnt=%0d exp we=0 cnt=1", vram_write_enable, fifo_count); end
    step();
    checks++; if (vram_write_enable !== 1'b1 || vram_address !== 12'h005 || vram_data !== 8'h42) begin errs++; $display("FAIL single_write got we=%b %h@%h exp we=1 42@005", vram_write_enable, vram_data, vram_address); end
    step();
    checks++; if (vram_write_enable !== 1'b0 || idle !== 1'b1) begin errs++; $display("FAIL single_idle got we=%b idle=%b exp 0 1", vram_write_enable, idle); end
    $display("single write 42@005 done");
  endtask

  task automatic test_fill_drain();
    int strobes;
    logic [7:0] d17;
    write_allowed = 0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1; in_data = 8'($urandom); in_address = 12'(i * 7);
      if (i == 16) d17 = in_data;
      if (i < 16) step();
    end
    checks++; if (fifo_count !== 5'd16 || in_ready !== 1'b0) begin errs++; $display("FAIL fill_full got cnt=%0d ready=%b exp 16 0", fifo_count, in_ready); end
    step();
    checks++; if (fifo_count !== 5'd16 || in_ready !== 1'b0) begin errs++; $display("FAIL fill_blocked got cnt=%0d ready=%b exp 16 0", fifo_count, in_ready); end
    write_allowed = 1;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      bit took;
      took = in_valid && (mq.size() < 16);
      step();
      if (took) in_valid = 0;
      checks++; if (vram_write_enable !== m_we) begin errs++; $display("FAIL drain_we cyc=%0d got=%b exp=%b", c, vram_write_enable, m_we); end
      if (m_we) begin
        strobes++;
        checks++; if (vram_address !== m_addr || vram_data !== m_data) begin errs++; $display("FAIL drain_data cyc=%0d got=%h@%h exp=%h@%h", c, vram_data, vram_address, m_data, m_addr); end
      end
      checks++; if (fifo_count !== 5'(mq.size()) || in_ready !== (mq.size() < 16)) begin errs++; $display("FAIL drain_count cyc=%0d got=%0d/%b exp=%0d", c, fifo_count, in_ready, mq.size()); end
    end
    checks++; if (strobes != 17 || vram_address !== 12'd112 || vram_data !== d17) begin errs++; $display("FAIL drain_last got n=%0d %h@%h exp n=17 %h@070", strobes, vram_data, vram_address, d17); end
    $display("fill 17 / drain done, strobes=%0d", strobes);
  endtask

  task automatic test_bad_address();
    int strobes;
    write_allowed = 1; strobes = 0;
    in_valid = 1; in_data = 8'hA5; in_address = 12'h8FF;
    step();
    in_address = 12'h900; in_data = 8'h5A;
    step();
    in_valid = 0;
    checks++; if (bad_address !== 1'b1) begin errs++; $display("FAIL bad_set got=%b exp=1", bad_address); end
    for (int c = 0; c < 4; c++) begin
      if (vram_write_enable) begin
        strobes++;
        checks++; if (vram_address !== 12'h8FF) begin errs++; $display("FAIL bad_written got=%h exp=8ff", vram_address); end
      end
      step();
    end
    checks++; if (strobes != 1 || fifo_count !== 5'd0) begin errs++; $display("FAIL bad_drop got n=%0d cnt=%0d exp n=1 cnt=0", strobes, fifo_count); end
    clear_error = 1; step(); clear_error = 0;
    checks++; if (bad_address !== 1'b0) begin errs++; $display("FAIL bad_clear got=%b exp=0", bad_address); end
    // Drop and clear in the same cycle: the drop wins.
    in_valid = 1; in_address = 12'hFFF; clear_error = 1; step(); in_valid = 0; clear_error = 0;
    checks++; if (bad_address !== 1'b1) begin errs++; $display("FAIL bad_set_wins got=%b exp=1", bad_address); end
    clear_error = 1; step(); clear_error = 0;
    $display("bad address 8ff/900 done");
  endtask

  task automatic test_stream();
    int sent, strobes, cyc;
    logic [11:0] next_addr;
    logic [15:0] total0;
    sent = 0; strobes = 0; cyc = 0; next_addr = 12'h000; total0 = m_total;
    while ((sent < 12'h900 || mq.size() != 0 || m_we) && cyc < 20000) begin
      bit took;
      write_allowed = ((cyc / 64) % 2) == 0;
      if (!in_valid && sent < 12'h900 && $urandom_range(0, 9) < 7) begin
        in_valid = 1; in_address = 12'(sent); in_data = 8'($urandom);
      end
      took = in_valid && (mq.size() < 16);
      step();
      if (took) begin in_valid = 0; sent++; end
      checks++; if (vram_write_enable !== m_we) begin errs++; $display("FAIL stream_we cyc=%0d got=%b exp=%b", cyc, vram_write_enable, m_we); end
      if (m_we && vram_write_enable) begin
        strobes++;
        checks++; if (vram_address !== next_addr || vram_address !== m_addr || vram_data !== m_data) begin errs++; $display("FAIL stream_data cyc=%0d got=%h@%h exp=%h@%h", cyc, vram_data, vram_address, m_data, next_addr); end
        next_addr = next_addr + 12'd1;
      end
      checks++; if (fifo_count !== 5'(mq.size()) || idle !== (mq.size() == 0 && !m_we)) begin errs++; $display("FAIL stream_count cyc=%0d got=%0d idle=%b exp=%0d", cyc, fifo_count, idle, mq.size()); end
      cyc++;
    end
    checks++; if (cyc >= 20000 || strobes != 12'h900) begin errs++; $display("FAIL stream_done got strobes=%0d cyc=%0d exp strobes=2304", strobes, cyc); end
`ifdef VRAM_WRITE_BUFFER_STATS_EN
    checks++; if (write_total !== total0 + 16'h0900) begin errs++; $display("FAIL stream_total got=%h exp=%h", write_total, total0 + 16'h0900); end
`endif
    $display("full-range stream done, strobes=%0d cycles=%0d", strobes, cyc);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_address    = 12'($urandom_range(0, 4095));
      in_data       = 8'($urandom);
      write_allowed = ($urandom_range(0, 2) != 0);
      clear_error   = ($urandom_range(0, 7) == 0);
      step();
      checks++; if (vram_write_enable !== m_we || (m_we && (vram_address !== m_addr || vram_data !== m_data))) begin errs++; $display("FAIL rand_out cyc=%0d got=%b %h@%h exp=%b %h@%h", c, vram_write_enable, vram_data, vram_address, m_we, m_data, m_addr); end
      checks++; if (fifo_count !== 5'(mq.size()) || in_ready !== (mq.size() < 16) || bad_address !== m_bad) begin errs++; $display("FAIL rand_state cyc=%0d got cnt=%0d rdy=%b bad=%b exp cnt=%0d bad=%b", c, fifo_count, in_ready, bad_address, mq.size(), m_bad); end
`ifdef VRAM_WRITE_BUFFER_STATS_EN
      checks++; if (write_total !== m_total) begin errs++; $display("FAIL rand_total cyc=%0d got=%h exp=%h", c, write_total, m_total); end
`endif
    end
    in_valid = 0; clear_error = 0;
    $display("random mix done");
  endtask

  task automatic test_async_reset();
    write_allowed = 1;
    while (mq.size() != 0 || m_we) step();
    write_allowed = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_address = 12'(12'h100 + i); in_data = 8'($urandom); step();
    end
    in_valid = 0;
    checks++; if (fifo_count !== 5'd7) begin errs++; $display("FAIL areset_pre got=%0d exp=7", fifo_count); end
    write_allowed = 1; step(); step();
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    checks++; if (vram_write_enable !== 1'b0 || fifo_count !== 5'd0 || vram_data !== 8'h00 || vram_address !== 12'h000) begin errs++; $display("FAIL areset_now got we=%b cnt=%0d %h@%h exp 0 0 00@000", vram_write_enable, fifo_count, vram_data, vram_address); end
    checks++; if (idle !== 1'b1 || bad_address !== 1'b0) begin errs++; $display("FAIL areset_flags got idle=%b bad=%b exp 1 0", idle, bad_address); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if (vram_write_enable !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL areset_stale cyc=%0d got we=%b rdy=%b exp 0 1", c, vram_write_enable, in_ready); end
    end
    $display("async reset mid-burst done");
  endtask

  initial begin
    errs = 0; checks = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_bad_address();
    test_stream();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
